// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO, DEPTH = 2**W entries of B bits, with
// occupancy count, full/empty and threshold flags, and sticky
// overflow/underflow error flags.
// Optional build macro FIFO_SYNC_FWFT_EN selects first-word-fall-through
// reads. Without the macro, reads are registered with one cycle of latency.
// Synchronous active-high clear (clr). It does not reset the storage array.
module fifo_sync #(
  parameter int unsigned B        = 8,
  parameter int unsigned W        = 3,
  parameter int unsigned AF_LEVEL = (2**W) - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [B-1:0] w_data,
  input  logic         rd_en,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned DEPTH = 2**W;
  localparam int unsigned CW    = W + 1;

  logic [B-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_waddr;
  logic [W-1:0]  r_raddr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_udf;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [CW-1:0] w_count_nxt;

  // A write is accepted when there is room, or when a read frees a slot in the same cycle.
  assign w_rd_acc = rd_en && !r_empty;
  assign w_wr_acc = wr_en && (!r_full || w_rd_acc);

  // Compute the next occupancy so the flags can be registered in step with count.
  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers, count, flags and sticky errors. A clear discards all entries.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_waddr <= r_waddr + W'(1);
      if (w_rd_acc) r_raddr <= r_raddr + W'(1);
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= CW'(AF_LEVEL));
      r_aempty <= (w_count_nxt <= CW'(AE_LEVEL));
      if (wr_en && !w_wr_acc) r_ovf <= 1'b1;
      if (rd_en && !w_rd_acc) r_udf <= 1'b1;
    end
  end

  // Storage array. It has no reset; stale contents are unreachable after a clear.
  always_ff @(posedge clk) begin
    if (!clr && w_wr_acc) begin
      r_mem[r_waddr] <= w_data;
    end
  end

`ifdef FIFO_SYNC_FWFT_EN
  // The head entry falls through directly from storage.
  assign r_data = r_mem[r_raddr];
`else
  logic [B-1:0] r_rdata;

  // Registered read data. It holds its value until the next accepted read.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= r_mem[r_raddr];
    end
  end

  assign r_data = r_rdata;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed and randomized check of fifo_sync (B=8, W=2)
// against a queue-based reference model.
module tb_fifo_sync;

  localparam int unsigned B   = 8;
  localparam int unsigned W   = 2;
  localparam int unsigned DEP = 4;
  localparam int unsigned AF  = 3;
  localparam int unsigned AE  = 1;

  logic         clk = 1'b0;
  logic         clr;
  logic         wr_en;
  logic [B-1:0] w_data;
  logic         rd_en;
  logic [B-1:0] r_data;
  logic         full;
  logic         empty;
  logic         almost_full;
  logic         almost_empty;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [B-1:0] q[$];
  logic [B-1:0] m_rdata;
  bit           m_ovf;
  bit           m_udf;

  fifo_sync #(.B(B), .W(W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk          (clk),
    .clr          (clr),
    .wr_en        (wr_en),
    .w_data       (w_data),
    .rd_en        (rd_en),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all observable outputs against the model.
  task automatic check_all();
    int n;
    n = q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEP));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
`ifdef FIFO_SYNC_FWFT_EN
    if (n != 0) check("r_data", 32'(r_data), 32'(q[0]));
`else
    check("r_data",       32'(r_data),       32'(m_rdata));
`endif
  endtask

  // One clock cycle: drive inputs, apply FIFO rules to the model, then check the outputs.
  task automatic step(input bit c, input bit w, input bit r, input logic [B-1:0] d);
    bit rd_ok;
    bit wr_ok;
    clr = c; wr_en = w; rd_en = r; w_data = d;
    @(posedge clk);
    rd_ok = r && (q.size() > 0);
    wr_ok = w && ((q.size() < DEP) || rd_ok);
    if (c) begin
      q.delete();
      m_rdata = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      if (w && !wr_ok) m_ovf = 1'b1;
      if (r && !rd_ok) m_udf = 1'b1;
      if (rd_ok) m_rdata = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; w_data = '0;
    m_rdata = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(negedge clk);

    // Reset, then fill with four words and drain them
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // A write to a full FIFO is dropped and sets overflow
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    step(0, 1, 0, 8'h55);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // Simultaneous read and write on a full FIFO, with pointer wrap
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 0, 8'h33);
    step(0, 1, 0, 8'h44);
    step(0, 1, 1, 8'h55);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00);

    // Simultaneous read and write on an empty FIFO: write only, underflow set
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h66);
    step(0, 0, 1, 8'h00);

    // A clear with a pending write discards earlier data
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'hA1);
    step(0, 1, 0, 8'hA2);
    step(0, 1, 0, 8'hA3);
    step(1, 1, 0, 8'hA4);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h77);
    step(0, 0, 1, 8'h00);

    // Randomized traffic with occasional clears
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      bit c;
      bit w;
      bit r;
      int bias;
      bias = (i / 250) % 3;
      c = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 99) < (bias == 0 ? 75 : (bias == 1 ? 25 : 50)));
      r = ($urandom_range(0, 99) < (bias == 0 ? 25 : (bias == 1 ? 75 : 50)));
      step(c, w, r, B'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
